// File: rtl/scale_by_2_n_pipe.sv
// scale_by_2_n_pipe: pipelined, valid/ready scaler computing out = in * 2^-n.
// A non-negative n shifts right with floor or round-half-up.
// A negative n shifts left and saturates on overflow.
// The result is computed on the accepted word and then carried through LAT register stages.
// Legal LAT is 1..4.
// Optional macro SCALE_OVF_CNT_EN adds a saturating 16-bit count of overflowed outputs (ovf_cnt).
module scale_by_2_n_pipe #(
  parameter int W     = 64,
  parameter int LOG2W = 6,
  parameter int LOG2N = 7,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOG2N-1:0] n,
  input  logic             rnd,
  input  logic [W-1:0]     in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out,
  output logic             ovf,
  output logic             inexact
`ifdef SCALE_OVF_CNT_EN
  ,
  output logic [15:0]      ovf_cnt
`endif
);

  typedef struct packed {
    logic [W-1:0] data;
    logic         ovf;
    logic         inexact;
  } result_t;

  logic [LAT-1:0] stage_valid;
  logic [LAT-1:0] can_load;
  result_t        stage_data [LAT];
  result_t        in_result;

  // Scale one word; right shifts use W+1 bits so the rounding add cannot wrap
  function automatic result_t scale(input logic [W-1:0] a,
                                    input logic [LOG2N-1:0] nn,
                                    input logic r);
    result_t          res;
    int               sh;
    logic [LOG2W-1:0] rs;
    logic [W:0]       ext;
    logic [W:0]       half;
    logic [W:0]       sum;
    logic [W:0]       shifted;
    logic [W-1:0]     mask;
    logic [W-1:0]     shl;
    logic [W-1:0]     back;
    logic [LOG2N:0]   mneg;
    res     = '0;
    sh      = 0;
    rs      = '0;
    ext     = '0;
    half    = '0;
    sum     = '0;
    shifted = '0;
    mask    = '0;
    shl     = '0;
    back    = '0;
    mneg    = '0;
    if (!nn[LOG2N-1]) begin
      sh = int'(nn);
      if (sh == 0) begin
        res.data = a;
      end else if (sh >= W) begin
        // Every bit of the operand is discarded: floor gives the sign, rounding gives zero
        res.data    = (r || !a[W-1]) ? '0 : '1;
        res.inexact = (a != '0);
      end else begin
        rs          = sh[LOG2W-1:0];
        ext         = {a[W-1], a};
        half        = {{W{1'b0}}, 1'b1} << (rs - {{(LOG2W-1){1'b0}}, 1'b1});
        sum         = r ? (ext + half) : ext;
        shifted     = $signed(sum) >>> rs;
        res.data    = shifted[W-1:0];
        mask        = ~({W{1'b1}} << rs);
        res.inexact = |(a & mask);
      end
    end else begin
      // Magnitude taken one bit wider so the most negative n still gives a positive shift
      mneg = -{nn[LOG2N-1], nn};
      sh   = int'(mneg);
      if (a == '0) begin
        res.data = '0;
      end else begin
        if (sh < W) begin
          shl  = a << sh;
          back = $signed(shl) >>> sh;
        end
        if (sh >= W || back != a) begin
          res.ovf  = 1'b1;
          res.data = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
          res.data = shl;
        end
      end
    end
    return res;
  endfunction

  // Arithmetic on the word presented at the input
  always_comb begin
    in_result = scale(in, n, rnd);
  end

  // A stage may load if it or any later stage has a hole, or the output drains
  always_comb begin
    can_load = '0;
    for (int i = 0; i < LAT; i++) begin
      can_load[i] = out_ready;
      for (int j = i; j < LAT; j++) begin
        if (!stage_valid[j]) can_load[i] = 1'b1;
      end
    end
  end

  assign in_ready = can_load[0];

  // Pipeline registers: valid bits always move, payload only when a real word moves
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stage_valid <= '0;
      for (int i = 0; i < LAT; i++) stage_data[i] <= '0;
    end else begin
      if (can_load[0]) begin
        stage_valid[0] <= in_valid;
        if (in_valid) stage_data[0] <= in_result;
      end
      for (int i = 1; i < LAT; i++) begin
        if (can_load[i]) begin
          stage_valid[i] <= stage_valid[i-1];
          if (stage_valid[i-1]) stage_data[i] <= stage_data[i-1];
        end
      end
    end
  end

  assign out_valid = stage_valid[LAT-1];
  assign out       = stage_data[LAT-1].data;
  assign ovf       = stage_data[LAT-1].ovf;
  assign inexact   = stage_data[LAT-1].inexact;

`ifdef SCALE_OVF_CNT_EN
  // Count saturated results once each as they leave, sticking at all-ones
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && ovf && ovf_cnt != 16'hFFFF) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_scale_by_2_n_pipe.sv
// tb_scale_by_2_n_pipe: scoreboard bench for scale_by_2_n_pipe at W=16, LAT=2.
// The ovf_cnt checks are built only when SCALE_OVF_CNT_EN is defined.
module tb_scale_by_2_n_pipe;

  typedef struct packed {
    logic [15:0] data;
    logic        ovf;
    logic        inexact;
  } exp_t;

  typedef struct {
    logic [15:0] d;
    logic [5:0]  nn;
    logic        r;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        arst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  n_val;
  logic        rnd_val;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        ovf;
  logic        inexact;
`ifdef SCALE_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  int   errors;
  int   checks;
  int   out_count;
  exp_t sb[$];
  vec_t table_v[16];

  scale_by_2_n_pipe #(.W(16), .LOG2W(4), .LOG2N(6), .LAT(2)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .n        (n_val),
    .rnd      (rnd_val),
    .in       (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out_data),
    .ovf      (ovf),
    .inexact  (inexact)
`ifdef SCALE_OVF_CNT_EN
    ,
    .ovf_cnt  (ovf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer arithmetic on 64-bit values
  function automatic exp_t model(input logic [15:0] d, input logic [5:0] nn, input logic r);
    exp_t   e;
    longint v;
    longint q;
    int     s;
    e = '0;
    v = longint'($signed(d));
    s = int'($signed(nn));
    if (s >= 0) begin
      if (s > 0 && r) q = (v + (longint'(1) << (s - 1))) >>> s;
      else            q = v >>> s;
      e.data    = q[15:0];
      e.inexact = ((v & ((longint'(1) << s) - 1)) != 0);
    end else begin
      q = v <<< (-s);
      if (q > 32767) begin
        e.data = 16'h7FFF;
        e.ovf  = 1'b1;
      end else if (q < -32768) begin
        e.data = 16'h8000;
        e.ovf  = 1'b1;
      end else begin
        e.data = q[15:0];
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one word and hold it until accepted; expectation enters the scoreboard on acceptance
  task automatic applyStimulus(input logic [15:0] d, input logic [5:0] nn, input logic r, input exp_t e);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    n_val    = nn;
    rnd_val  = r;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("accept", 32'(in_ready), 32'd1);
    if (in_ready) sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Pop and compare every output transfer
  always @(negedge clk) begin
    if (arst_n && out_valid && out_ready) begin
      out_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got out=%h ovf=%b inexact=%b with nothing pending",
                 out_data, ovf, inexact);
      end else begin
        checkOutput("word", 32'({out_data, ovf, inexact}), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   idx;
    int   cyc;
    int   base;
    exp_t e0;

    errors    = 0;
    checks    = 0;
    out_count = 0;
    arst_n    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    n_val     = '0;
    rnd_val   = 1'b0;
    out_ready = 1'b1;

    table_v[0]  = '{16'hFFF3, 6'd2,  1'b0, '{16'hFFFC, 1'b0, 1'b1}};
    table_v[1]  = '{16'hFFF3, 6'd2,  1'b1, '{16'hFFFD, 1'b0, 1'b1}};
    table_v[2]  = '{16'h0006, 6'd2,  1'b1, '{16'h0002, 1'b0, 1'b1}};
    table_v[3]  = '{16'h7FFF, 6'd20, 1'b1, '{16'h0000, 1'b0, 1'b1}};
    table_v[4]  = '{16'h8000, 6'd20, 1'b0, '{16'hFFFF, 1'b0, 1'b1}};
    table_v[5]  = '{16'h0123, 6'h3C, 1'b0, '{16'h1230, 1'b0, 1'b0}};
    table_v[6]  = '{16'h0900, 6'h3C, 1'b0, '{16'h7FFF, 1'b1, 1'b0}};
    table_v[7]  = '{16'hF700, 6'h3C, 1'b1, '{16'h8000, 1'b1, 1'b0}};
    table_v[8]  = '{16'h0000, 6'h20, 1'b0, '{16'h0000, 1'b0, 1'b0}};
    table_v[9]  = '{16'h1234, 6'd0,  1'b1, '{16'h1234, 1'b0, 1'b0}};
    table_v[10] = '{16'h0008, 6'd3,  1'b0, '{16'h0001, 1'b0, 1'b0}};
    table_v[11] = '{16'hFFFF, 6'd1,  1'b1, '{16'h0000, 1'b0, 1'b1}};
    table_v[12] = '{16'hFFFF, 6'h31, 1'b0, '{16'h8000, 1'b0, 1'b0}};
    table_v[13] = '{16'h0001, 6'h31, 1'b0, '{16'h7FFF, 1'b1, 1'b0}};
    table_v[14] = '{16'h0005, 6'd3,  1'b1, '{16'h0001, 1'b0, 1'b1}};
    table_v[15] = '{16'hFFF4, 6'd2,  1'b1, '{16'hFFFD, 1'b0, 1'b0}};

    // Reset values
    #3;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out", 32'(out_data), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    checkOutput("reset_inexact", 32'(inexact), 32'd0);
    repeat (2) @(posedge clk);
    #2 arst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Latency of a single word
    in_valid = 1'b1;
    in_data  = 16'hFFF3;
    n_val    = 6'd2;
    rnd_val  = 1'b0;
    @(negedge clk);
    checkOutput("accept_first", 32'(in_ready), 32'd1);
    sb.push_back('{16'hFFFC, 1'b0, 1'b1});
    @(posedge clk);
    #1 in_valid = 1'b0;
    checkOutput("latency_not_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("latency_exact", 32'(out_valid), 32'd1);
    waitDrain();

    // Table of hand-computed vectors, back to back
    for (int i = 0; i < 16; i++) begin
      applyStimulus(table_v[i].d, table_v[i].nn, table_v[i].r, table_v[i].e);
    end
    waitDrain();

    // Eight words against a stalled output
    out_ready = 1'b0;
    idx       = 0;
    base      = out_count;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = 16'(idx * 16'h0111 + 16'h0805);
      n_val    = 6'(idx - 3);
      rnd_val  = idx[0];
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(in_data, n_val, rnd_val));
        idx++;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("accepted_while_stalled", 32'(idx), 32'd2);
    checkOutput("in_ready_when_full", 32'(in_ready), 32'd0);
    e0 = model(16'h0805, 6'h3D, 1'b0);
    checkOutput("held_while_stalled", 32'({out_valid, out_data, ovf, inexact}), 32'({1'b1, e0}));

    out_ready = 1'b1;
    cyc       = 0;
    while ((idx < 8 || sb.size() != 0) && cyc < 40) begin
      if (idx < 8) begin
        in_valid = 1'b1;
        in_data  = 16'(idx * 16'h0111 + 16'h0805);
        n_val    = 6'(idx - 3);
        rnd_val  = idx[0];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back(model(in_data, n_val, rnd_val));
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("stream_drain_cycles", 32'(cyc), 32'd8);
    checkOutput("stream_count", 32'(out_count - base), 32'd8);

    // Random words under random back-pressure
    idx  = 0;
    cyc  = 0;
    base = out_count;
    while ((idx < 40 || sb.size() != 0) && cyc < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (idx < 40) begin
        in_valid = 1'($urandom_range(0, 3) != 0);
        in_data  = 16'($urandom);
        n_val    = 6'($urandom);
        rnd_val  = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back(model(in_data, n_val, rnd_val));
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("random_pending", 32'(sb.size()), 32'd0);
    checkOutput("random_count", 32'(out_count - base), 32'd40);

    // Reset with two words in flight
    out_ready = 1'b0;
    applyStimulus(16'h0040, 6'd1, 1'b0, model(16'h0040, 6'd1, 1'b0));
    applyStimulus(16'h0050, 6'd1, 1'b0, model(16'h0050, 6'd1, 1'b0));
    checkOutput("inflight_valid", 32'(out_valid), 32'd1);
    #2 arst_n = 1'b0;
    #1;
    checkOutput("flush_immediate", 32'(out_valid), 32'd0);
    checkOutput("flush_out_zero", 32'({out_data, ovf, inexact}), 32'd0);
    sb.delete();
    @(negedge clk);
    arst_n    = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("no_stale_word", 32'(out_valid), 32'd0);
    end
    checkOutput("in_ready_after_flush", 32'(in_ready), 32'd1);

`ifdef SCALE_OVF_CNT_EN
    // Overflow counter: three saturating words, then one held under back-pressure
    checkOutput("ovf_cnt_reset", 32'(ovf_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h0900, 6'h3C, 1'b0, '{16'h7FFF, 1'b1, 1'b0});
    end
    waitDrain();
    checkOutput("ovf_cnt_three", 32'(ovf_cnt), 32'd3);
    out_ready = 1'b0;
    applyStimulus(16'hF700, 6'h3C, 1'b0, '{16'h8000, 1'b1, 1'b0});
    repeat (5) @(posedge clk);
    #1;
    checkOutput("ovf_cnt_stalled", 32'(ovf_cnt), 32'd3);
    out_ready = 1'b1;
    waitDrain();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("ovf_cnt_once", 32'(ovf_cnt), 32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
